// File: rtl/config_port_arbiter.sv
// Arbitrates the fabric configuration word port between the UART source (src0) and the
// parallel host source (src1), granting whole sessions framed by ComActive.
module config_port_arbiter #(
  parameter int IDLE_TIMEOUT  = 1024,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int DROP_WIDTH    = 8
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  src0_active,
  input  logic                  src0_strobe,
  input  logic [31:0]           src0_data,
  input  logic                  src1_active,
  input  logic                  src1_strobe,
  input  logic [31:0]           src1_data,
  output logic [31:0]           WriteData,
  output logic                  WriteStrobe,
  output logic                  ComActive,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_OWN,
    S_RELEASE
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1);
  localparam int DSUM_W = DROP_WIDTH + 1;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;          // 0 = src0, 1 = src1
  logic                     last_owner_q, last_owner_d;
  logic                     arm_cnt_q, arm_cnt_d;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;

  logic                     owner_active, owner_strobe;
  logic [31:0]              owner_data;
  logic                     fwd0, fwd1, fwd;
  logic                     drop0, drop1;
  logic [DSUM_W-1:0]        drop_sum;
  logic [DROP_WIDTH-1:0]    drop_d;
  logic                     com_d, busy_d;
  logic [1:0]               grant_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    arm_cnt_d    = 1'b0;
    idle_cnt_d   = '0;

    owner_active = owner_q ? src1_active : src0_active;
    owner_strobe = owner_q ? src1_strobe : src0_strobe;
    owner_data   = owner_q ? src1_data   : src0_data;

    fwd0 = (state_q == S_OWN) && !owner_q && src0_strobe;
    fwd1 = (state_q == S_OWN) &&  owner_q && src1_strobe;
    fwd  = fwd0 || fwd1;

    unique case (state_q)
      S_IDLE: begin
        if (src0_active && src1_active) begin
          owner_d = ~last_owner_q;
          state_d = S_ARM;
        end else if (src0_active) begin
          owner_d = 1'b0;
          state_d = S_ARM;
        end else if (src1_active) begin
          owner_d = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        arm_cnt_d = ~arm_cnt_q;
        if (arm_cnt_q) state_d = S_OWN;
      end
      S_OWN: begin
        idle_cnt_d = owner_strobe ? '0 : idle_cnt_q + TIMEOUT_WIDTH'(1);
        // An owner strobe in the timeout cycle keeps the session alive.
        if (!owner_active || (!owner_strobe && idle_cnt_q == TIMEOUT_LAST))
          state_d = S_RELEASE;
      end
      S_RELEASE: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state register.
    com_d   = (state_d == S_ARM) || (state_d == S_OWN);
    busy_d  = (state_d != S_IDLE);
    grant_d = (state_d == S_OWN) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;

    drop0    = src0_strobe && !fwd0;
    drop1    = src1_strobe && !fwd1;
    drop_sum = {1'b0, drop_count} + DSUM_W'(drop0) + DSUM_W'(drop1);
    drop_d   = drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      arm_cnt_q    <= 1'b0;
      idle_cnt_q   <= '0;
      WriteData    <= '0;
      WriteStrobe  <= 1'b0;
      ComActive    <= 1'b0;
      grant        <= 2'b00;
      busy         <= 1'b0;
      drop_count   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      arm_cnt_q    <= arm_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      WriteStrobe  <= fwd;
      if (fwd) WriteData <= owner_data;
      ComActive    <= com_d;
      grant        <= grant_d;
      busy         <= busy_d;
      drop_count   <= drop_d;
    end
  end

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: forwarded words go through a queue scoreboard,
// session framing, arbitration, timeout and drop counting are checked at each step.
module tb_config_port_arbiter;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        src0_active = 1'b0, src0_strobe = 1'b0;
  logic [31:0] src0_data = '0;
  logic        src1_active = 1'b0, src1_strobe = 1'b0;
  logic [31:0] src1_data = '0;
  logic [31:0] WriteData;
  logic        WriteStrobe, ComActive, busy;
  logic [1:0]  grant;
  logic [7:0]  drop_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  int          exp_drop = 0;

  always #5 CLK = ~CLK;

  config_port_arbiter #(
    .IDLE_TIMEOUT (8),
    .TIMEOUT_WIDTH(16),
    .DROP_WIDTH   (8)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .src0_active(src0_active),
    .src0_strobe(src0_strobe),
    .src0_data  (src0_data),
    .src1_active(src1_active),
    .src1_strobe(src1_strobe),
    .src1_data  (src1_data),
    .WriteData  (WriteData),
    .WriteStrobe(WriteStrobe),
    .ComActive  (ComActive),
    .grant      (grant),
    .busy       (busy),
    .drop_count (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic com, input logic [1:0] g, input logic b);
    chk({tag, "/ComActive"}, 32'(ComActive), 32'(com));
    chk({tag, "/grant"},     32'(grant),     32'(g));
    chk({tag, "/busy"},      32'(busy),      32'(b));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_drop = 0;
    tick();
  endtask

  // Scoreboard consumer: every WriteStrobe must match the oldest expected word.
  always begin : monitor
    logic [31:0] exp_w;
    @(posedge CLK);
    #2;
    if (WriteStrobe === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_word: observed %h expected no word", WriteData);
      end else begin
        exp_w = sb.pop_front();
        chk("word", WriteData, exp_w);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] words [3];
    words[0] = 32'hFAB0_FAB1;
    words[1] = 32'h0000_0001;
    words[2] = 32'hDEAD_BEEF;

    // Reset values
    tick();
    tick();
    chk("rst/WriteData", WriteData, 32'h0);
    chk("rst/WriteStrobe", 32'(WriteStrobe), 32'h0);
    chk_ctl("rst", 1'b0, 2'b00, 1'b0);
    chk("rst/drop", 32'(drop_count), 32'h0);
    resetn = 1'b1;
    tick();

    // 1: single source session, three words out one cycle late
    src0_active = 1'b1;
    tick(); chk_ctl("t1_arm1", 1'b1, 2'b00, 1'b1);
    tick(); chk_ctl("t1_arm2", 1'b1, 2'b00, 1'b1);
    tick(); chk_ctl("t1_own", 1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      src0_strobe = 1'b1;
      src0_data   = words[i];
      sb.push_back(words[i]);
      tick();
      chk("t1_latency", WriteData, words[i]);
    end
    src0_strobe = 1'b0;
    src0_data   = 32'h1111_2222;
    tick();
    chk("t1_ws_low", 32'(WriteStrobe), 32'h0);
    chk("t1_wd_hold", WriteData, 32'hDEAD_BEEF);
    src0_active = 1'b0;
    tick(); chk_ctl("t1_rel", 1'b0, 2'b00, 1'b1);
    tick(); chk_ctl("t1_idle", 1'b0, 2'b00, 1'b0);

    // 2: tie after reset goes to src0, hand-over gap, round-robin on re-request
    do_reset();
    src0_active = 1'b1;
    src1_active = 1'b1;
    tick(); tick(); tick();
    chk_ctl("t2_own0", 1'b1, 2'b01, 1'b1);
    src0_active = 1'b0;
    tick(); chk_ctl("t2_rel", 1'b0, 2'b00, 1'b1);
    tick(); chk_ctl("t2_gap", 1'b0, 2'b00, 1'b0);
    tick(); chk_ctl("t2_arm", 1'b1, 2'b00, 1'b1);
    tick(); tick();
    chk_ctl("t2_own1", 1'b1, 2'b10, 1'b1);
    src0_active = 1'b1;
    src1_active = 1'b0;
    tick(); chk_ctl("t2_rel1", 1'b0, 2'b00, 1'b1);
    src1_active = 1'b1;
    tick(); tick(); tick(); tick();
    chk_ctl("t2_rr", 1'b1, 2'b01, 1'b1);
    src0_active = 1'b0;
    src1_active = 1'b0;
    tick(); tick();

    // 3: drops during ARM and from the non-owner, forward on falling active, dual drop
    do_reset();
    src0_active = 1'b1;
    tick();
    src0_strobe = 1'b1;
    src0_data   = 32'hBAD0_0000;
    tick();
    exp_drop = 1;
    src0_strobe = 1'b0;
    tick();
    chk_ctl("t3_own", 1'b1, 2'b01, 1'b1);
    chk("t3_arm_drop", 32'(drop_count), 32'(exp_drop));
    for (int i = 0; i < 5; i++) begin
      src1_strobe = 1'b1;
      src1_data   = 32'hBAD1_0000 + 32'(i);
      tick();
      exp_drop++;
    end
    src1_strobe = 1'b0;
    chk("t3_no_fwd", 32'(WriteStrobe), 32'h0);
    chk("t3_drop6", 32'(drop_count), 32'(exp_drop));
    src0_strobe = 1'b1;
    src0_data   = 32'h1234_5678;
    sb.push_back(32'h1234_5678);
    src0_active = 1'b0;
    tick();
    src0_strobe = 1'b0;
    chk("t3_last_ws", 32'(WriteStrobe), 32'h1);
    chk_ctl("t3_rel", 1'b0, 2'b00, 1'b1);
    tick();
    src0_strobe = 1'b1;
    src1_strobe = 1'b1;
    tick();
    exp_drop += 2;
    src0_strobe = 1'b0;
    src1_strobe = 1'b0;
    chk("t3_dual_drop", 32'(drop_count), 32'(exp_drop));

    // 4: idle timeout of 8 silent cycles, and a strobe in the timeout cycle cancels it
    src0_active = 1'b1;
    tick(); tick(); tick();
    chk_ctl("t4_own", 1'b1, 2'b01, 1'b1);
    repeat (7) tick();
    chk_ctl("t4_pre", 1'b1, 2'b01, 1'b1);
    tick(); chk_ctl("t4_timeout", 1'b0, 2'b00, 1'b1);
    tick(); chk_ctl("t4_gap", 1'b0, 2'b00, 1'b0);
    tick(); chk_ctl("t4_rearm", 1'b1, 2'b00, 1'b1);
    tick(); tick();
    chk_ctl("t4_own2", 1'b1, 2'b01, 1'b1);
    repeat (7) tick();
    src0_strobe = 1'b1;
    src0_data   = 32'hCAFE_0007;
    sb.push_back(32'hCAFE_0007);
    tick();
    src0_strobe = 1'b0;
    chk_ctl("t4_cancel", 1'b1, 2'b01, 1'b1);
    repeat (7) tick();
    chk_ctl("t4_cont", 1'b1, 2'b01, 1'b1);
    src0_active = 1'b0;
    tick(); tick();

    // 5: asynchronous reset while a word is on the port
    src0_active = 1'b1;
    tick(); tick(); tick();
    src0_strobe = 1'b1;
    src0_data   = 32'hA5A5_0005;
    sb.push_back(32'hA5A5_0005);
    tick();
    src0_strobe = 1'b0;
    chk("t5_ws", 32'(WriteStrobe), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    exp_drop = 0;
    chk("t5/WriteData", WriteData, 32'h0);
    chk("t5/WriteStrobe", 32'(WriteStrobe), 32'h0);
    chk_ctl("t5_async", 1'b0, 2'b00, 1'b0);
    chk("t5/drop", 32'(drop_count), 32'h0);
    tick(); tick();
    resetn = 1'b1;
    tick(); chk_ctl("t5_restart_arm", 1'b1, 2'b00, 1'b1);
    tick(); tick();
    chk_ctl("t5_restart_own", 1'b1, 2'b01, 1'b1);
    src0_active = 1'b0;
    tick(); tick();

    // 6: drop counter saturation (two strobes per cycle, 300 total)
    src0_strobe = 1'b1;
    src1_strobe = 1'b1;
    repeat (127) tick();
    exp_drop = 254;
    chk("t6_254", 32'(drop_count), 32'(exp_drop));
    tick();
    exp_drop = 255;
    chk("t6_sat", 32'(drop_count), 32'(exp_drop));
    repeat (22) tick();
    chk("t6_hold", 32'(drop_count), 32'(exp_drop));
    src0_strobe = 1'b0;
    src1_strobe = 1'b0;

    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
